bus_sequencer: RTL

Generates the per-phi-cycle bus timing around the vicii core. From the 4x dot clock it derives `clk_phi`, the DRAM strobes (`ras`, `cas`, and the row/column `mux`), and the bus-ownership signals `ba`, `aec` and `vic_write_ab`. It also arbitrates phi2 between the CPU and VIC stolen cycles. It sits between the vicii fetch logic, which raises `steal_req`, and the top-level bus tri-state drivers.

---
 rtl/bus_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: per-phi-cycle bus timing generator for the vicii core.
// Derives the phi clock, DRAM strobes and bus-ownership signals from the
// 4x dot clock (32 ticks per phi cycle). It also schedules VIC steals of
// phi2, with the mandatory three-cycle BA warning before each steal run.
module bus_sequencer #(
    parameter int RAS_FALL = 5,
    parameter int MUX_RISE = 7,
    parameter int CAS_FALL = 9
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       steal_req,
    output logic [4:0] cycle_pos,
    output logic       clk_phi,
    output logic       ba,
    output logic       aec,
    output logic       vic_write_ab,
    output logic       ras,
    output logic       cas,
    output logic       mux,
    output logic       stolen
);

    // Strobe thresholds, narrowed to the width of the local position.
    localparam logic [3:0] LP_RAS_FALL = 4'(RAS_FALL);
    localparam logic [3:0] LP_MUX_RISE = 4'(MUX_RISE);
    localparam logic [3:0] LP_CAS_FALL = 4'(CAS_FALL);

    logic [4:0] r_pos;
    logic [1:0] r_ba_cnt;
    logic       r_ba;
    logic       r_stolen;
    logic       r_clk_phi;
    logic       r_aec;
    logic       r_vic_write_ab;
    logic       r_ras;
    logic       r_cas;
    logic       r_mux;

    logic [4:0] w_pos_nxt;
    logic [3:0] w_l_nxt;
    logic       w_phi2_nxt;
    logic       w_wrap;
    logic       w_stolen_nxt;
    logic       w_ba_nxt;
    logic [1:0] w_ba_cnt_nxt;

    // The counter free-runs and wraps naturally from 31 to 0.
    assign w_pos_nxt  = r_pos + 5'd1;
    assign w_l_nxt    = w_pos_nxt[3:0];
    assign w_phi2_nxt = w_pos_nxt[4];
    assign w_wrap     = (w_pos_nxt == 5'd0);

    // Steal scheduling: only the sample taken on the wrap into position 0
    // matters; steal_req is ignored for the rest of the phi cycle.
    always_comb begin
        w_stolen_nxt = r_stolen;
        w_ba_nxt     = r_ba;
        w_ba_cnt_nxt = r_ba_cnt;
        if (w_wrap) begin
            if (steal_req) begin
                w_stolen_nxt = (r_ba_cnt == 2'd3);
                w_ba_cnt_nxt = (r_ba_cnt == 2'd3) ? 2'd3 : r_ba_cnt + 2'd1;
                w_ba_nxt     = 1'b0;
            end else begin
                w_stolen_nxt = 1'b0;
                w_ba_cnt_nxt = 2'd0;
                w_ba_nxt     = 1'b1;
            end
        end
    end

    // All outputs are registered and decoded from the next counter value so
    // they line up with the cycle_pos they describe.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_pos          <= 5'd0;
            r_ba_cnt       <= 2'd0;
            r_ba           <= 1'b1;
            r_stolen       <= 1'b0;
            r_clk_phi      <= 1'b0;
            r_aec          <= 1'b0;
            r_vic_write_ab <= 1'b0;
            r_ras          <= 1'b1;
            r_cas          <= 1'b1;
            r_mux          <= 1'b0;
        end else begin
            r_pos          <= w_pos_nxt;
            r_ba_cnt       <= w_ba_cnt_nxt;
            r_ba           <= w_ba_nxt;
            r_stolen       <= w_stolen_nxt;
            r_clk_phi      <= w_phi2_nxt;
            r_aec          <= w_phi2_nxt & ~w_stolen_nxt;
            // Position 0 is left undriven for address-bus turnaround.
            r_vic_write_ab <= (~w_phi2_nxt & (w_l_nxt != 4'd0)) |
                              (w_phi2_nxt & w_stolen_nxt);
            r_ras          <= ~(w_l_nxt >= LP_RAS_FALL);
            r_cas          <= ~(w_l_nxt >= LP_CAS_FALL);
            r_mux          <= (w_l_nxt >= LP_MUX_RISE);
        end
    end

    assign cycle_pos    = r_pos;
    assign clk_phi      = r_clk_phi;
    assign ba           = r_ba;
    assign aec          = r_aec;
    assign vic_write_ab = r_vic_write_ab;
    assign ras          = r_ras;
    assign cas          = r_cas;
    assign mux          = r_mux;
    assign stolen       = r_stolen;

endmodule
